// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame-size limits, np code decode and the frame-tracking FSM state type.
// Used by fft_peak_detect and by other FFT blocks that accept the same np frame-size code.
package fft_pkg;

    // log2 of the largest supported frame (2048 points)
    localparam int unsigned MAX_LOG2N = 11;
    // log2 of the smallest frame (np code 0 -> 8 points)
    localparam int unsigned MIN_LOG2N = 3;
    // Largest meaningful np code; codes above it alias to it
    localparam logic [3:0]  NP_MAX    = 4'd8;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } fft_state_e;

    // np code -> log2(frame points), saturating codes 9..15 to the 2048-point frame
    function automatic logic [3:0] np_to_log2(input logic [3:0] np);
        logic [3:0] code;
        code = (np > NP_MAX) ? NP_MAX : np;
        return code + 4'(MIN_LOG2N);
    endfunction

    // np code -> number of points in the frame
    function automatic int unsigned np_to_point(input logic [3:0] np);
        return 32'd1 << np_to_log2(np);
    endfunction

endpackage

// File: rtl/cplx_pwr.sv
// Two-stage squared-magnitude pipeline: stage 1 registers re^2 and im^2 (signed, full
// precision), stage 2 registers their unsigned sum. Qualifiers ride along with the data.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in, sop_in         input qualifiers
//   y_re, y_im               signed complex sample
//   power                    unsigned y_re^2 + y_im^2, 2 cycles after the input
//   power_valid, power_sop   qualifiers delayed by 2 cycles
module cplx_pwr
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic                           sop_in,
    input  logic signed [DATA_WIDTH-1:0]   y_re,
    input  logic signed [DATA_WIDTH-1:0]   y_im,
    output logic        [2*DATA_WIDTH-1:0] power,
    output logic                           power_valid,
    output logic                           power_sop
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] re_ext;
    logic signed [PW-1:0] im_ext;
    logic signed [PW-1:0] re_sq_q;
    logic signed [PW-1:0] im_sq_q;
    logic                 valid_q;
    logic                 sop_q;

    // Sign-extend before multiplying so the product is computed at full width
    assign re_ext = PW'(y_re);
    assign im_ext = PW'(y_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_sq_q     <= '0;
            im_sq_q     <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            power       <= '0;
            power_valid <= 1'b0;
            power_sop   <= 1'b0;
        end else begin
            re_sq_q     <= re_ext * re_ext;
            im_sq_q     <= im_ext * im_ext;
            valid_q     <= valid_in;
            sop_q       <= sop_in & valid_in;
            // Each square is at most 2^(PW-2), so the unsigned sum cannot wrap
            power       <= $unsigned(re_sq_q) + $unsigned(im_sq_q);
            power_valid <= valid_q;
            power_sop   <= sop_q;
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin power and per-frame peak/energy detector for a natural-order FFT output stream.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   np                       frame size code (0 -> 8 ... 8 -> 2048), sampled with sop_in
//   valid_in, sop_in         bin valid, first bin of frame
//   y_re, y_im               signed FFT bin
//   power_out/_valid/_sop    streamed |y|^2, 2 cycles after the input
//   peak_idx, peak_pwr       location and value of the largest power in the last frame
//   energy                   sum of power over the last frame
//   done                     pulse: results updated
//   frame_err                pulse: frame aborted by an early sop_in
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LOG2N  = fft_pkg::MAX_LOG2N
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [3:0]                               np,
    input  logic                                     valid_in,
    input  logic                                     sop_in,
    input  logic signed [DATA_WIDTH-1:0]             y_re,
    input  logic signed [DATA_WIDTH-1:0]             y_im,
    output logic        [2*DATA_WIDTH-1:0]           power_out,
    output logic                                     power_valid,
    output logic                                     power_sop,
    output logic        [MAX_LOG2N-1:0]              peak_idx,
    output logic        [2*DATA_WIDTH-1:0]           peak_pwr,
    output logic        [2*DATA_WIDTH+MAX_LOG2N-1:0] energy,
    output logic                                     done,
    output logic                                     frame_err
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned EW = PW + MAX_LOG2N;

    fft_state_e           state_q;
    logic [MAX_LOG2N-1:0] cnt_q;
    logic [MAX_LOG2N-1:0] last_q;
    logic [PW-1:0]        run_max_q;
    logic [MAX_LOG2N-1:0] run_idx_q;
    logic [EW-1:0]        run_sum_q;
    logic [3:0]           np_p1_q;
    logic [3:0]           np_p2_q;

    logic [MAX_LOG2N-1:0] frame_last;
    logic [MAX_LOG2N-1:0] cnt_inc;
    logic [EW-1:0]        sum_inc;
    logic                 gt;

    cplx_pwr #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cplx_pwr (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .sop_in      (sop_in),
        .y_re        (y_re),
        .y_im        (y_im),
        .power       (power_out),
        .power_valid (power_valid),
        .power_sop   (power_sop)
    );

    // np travels alongside the power pipeline so it lines up with power_sop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            np_p1_q <= '0;
            np_p2_q <= '0;
        end else begin
            np_p1_q <= np;
            np_p2_q <= np_p1_q;
        end
    end

    always_comb begin
        frame_last = MAX_LOG2N'((32'd1 << np_to_log2(np_p2_q)) - 32'd1);
        cnt_inc    = cnt_q + MAX_LOG2N'(1);
        sum_inc    = run_sum_q + EW'(power_out);
        // Strictly greater: on ties the earliest bin keeps the peak
        gt         = power_out > run_max_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            run_sum_q <= '0;
            peak_idx  <= '0;
            peak_pwr  <= '0;
            energy    <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            if (power_valid) begin
                if (power_sop) begin
                    // In StRun the counter never reaches the last bin, so any sop there is early
                    frame_err <= (state_q == StRun);
                    state_q   <= StRun;
                    cnt_q     <= '0;
                    last_q    <= frame_last;
                    run_max_q <= power_out;
                    run_idx_q <= '0;
                    run_sum_q <= EW'(power_out);
                end else if (state_q == StRun) begin
                    cnt_q     <= cnt_inc;
                    run_sum_q <= sum_inc;
                    if (gt) begin
                        run_max_q <= power_out;
                        run_idx_q <= cnt_inc;
                    end
                    if (cnt_inc == last_q) begin
                        state_q  <= StIdle;
                        done     <= 1'b1;
                        peak_idx <= gt ? cnt_inc : run_idx_q;
                        peak_pwr <= gt ? power_out : run_max_q;
                        energy   <= sum_inc;
                    end
                end
            end
        end
    end

endmodule
